// File: rtl/tick_timer_multi.sv
// ============================================================================
// Module      : tick_timer_multi
// Description : Multi-channel tick timer. Each channel divides clk to a tick
//               rate and counts ticks with pause, saturate/wrap modes and a
//               done flag. Define TICK_SHARED_PRESCALER_EN to use a single
//               free-running prescaler that all channels share.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_timer_multi #(
    parameter int CLK_FREQ  = 25000000,
    parameter int TICK_RATE = 1000,
    parameter int MAX_TICKS = 96000,
    parameter int CHANNELS  = 2,
    localparam int DIV      = CLK_FREQ / TICK_RATE,
    localparam int TW       = $clog2(MAX_TICKS + 1),
    localparam int PW       = $clog2(DIV)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    start,
    input  logic [CHANNELS-1:0]    pause,
    input  logic [CHANNELS-1:0]    wrap_mode,
    output logic [CHANNELS*TW-1:0] ticks,
    output logic [CHANNELS-1:0]    tick_pulse,
    output logic [CHANNELS-1:0]    done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [PW-1:0] c_PRE_LAST = PW'(DIV - 1);
    localparam logic [TW-1:0] c_CNT_LAST = TW'(MAX_TICKS - 1);
    localparam logic [TW-1:0] c_CNT_MAX  = TW'(MAX_TICKS);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_timer_multi: CLK_FREQ/TICK_RATE must be >= 2");
        end
        if (MAX_TICKS < 1) begin : g_bad_max
            $error("tick_timer_multi: MAX_TICKS must be >= 1");
        end
        if (CHANNELS < 1) begin : g_bad_ch
            $error("tick_timer_multi: CHANNELS must be >= 1");
        end
    endgenerate

`ifdef TICK_SHARED_PRESCALER_EN
    logic [PW-1:0] r_shared_pre;
    logic          w_shared_wrap;

    assign w_shared_wrap = (r_shared_pre == c_PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shared_pre <= '0;
        end else begin
            r_shared_pre <= w_shared_wrap ? '0 : r_shared_pre + PW'(1);
        end
    end
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]    r_state;
        logic [TW-1:0] r_count;
        logic          r_tick;
        logic          r_done;
        logic          r_wrap;
        logic          w_tick;
        logic          w_step;

        // A step is any edge spent counting: RUN, or the HOLD exit edge.
        assign w_step = start[i] && !pause[i] && (r_state == c_RUN || r_state == c_HOLD);

`ifdef TICK_SHARED_PRESCALER_EN
        assign w_tick = w_shared_wrap;
`else
        logic [PW-1:0] r_pre;

        assign w_tick = (r_pre == c_PRE_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pre <= '0;
            end else if (!start[i] || r_state == c_IDLE) begin
                r_pre <= '0;
            end else if (w_step) begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
            end
        end
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= c_IDLE;
                r_count <= '0;
                r_tick  <= 1'b0;
                r_done  <= 1'b0;
                r_wrap  <= 1'b0;
            end else if (!start[i]) begin
                r_state <= c_IDLE;
                r_count <= '0;
                r_tick  <= 1'b0;
                r_done  <= 1'b0;
                r_wrap  <= 1'b0;
            end else begin
                r_tick <= 1'b0;
                case (r_state)
                    c_IDLE: begin
                        r_state <= c_RUN;
                        r_wrap  <= wrap_mode[i];
                        r_done  <= 1'b0;
                    end
                    c_RUN, c_HOLD: begin
                        r_done <= 1'b0;
                        if (pause[i]) begin
                            r_state <= c_HOLD;
                        end else begin
                            r_state <= c_RUN;
                            if (w_tick) begin
                                r_tick <= 1'b1;
                                if (r_count == c_CNT_LAST) begin
                                    r_done <= 1'b1;
                                    if (r_wrap) begin
                                        r_count <= '0;
                                    end else begin
                                        r_count <= c_CNT_MAX;
                                        r_state <= c_DONE;
                                    end
                                end else begin
                                    r_count <= r_count + TW'(1);
                                end
                            end
                        end
                    end
                    c_DONE: begin
                        r_done <= 1'b1;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end

        assign ticks[i*TW +: TW] = r_count;
        assign tick_pulse[i]     = r_tick;
        assign done[i]           = r_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_timer_multi.sv
// ============================================================================
// Module      : tb_tick_timer_multi
// Description : Directed self-checking bench for tick_timer_multi (DIV=10,
//               MAX_TICKS=5, two channels).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_timer_multi;

    localparam int TW = 3;

    logic          clk;
    logic          rst_n;
    logic [1:0]    start;
    logic [1:0]    pause;
    logic [1:0]    wrap_mode;
    logic [2*TW-1:0] ticks;
    logic [1:0]    tick_pulse;
    logic [1:0]    done;

    int n_checks = 0;
    int n_fail   = 0;

    tick_timer_multi #(
        .CLK_FREQ  (100),
        .TICK_RATE (10),
        .MAX_TICKS (5),
        .CHANNELS  (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .wrap_mode  (wrap_mode),
        .ticks      (ticks),
        .tick_pulse (tick_pulse),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_ch(input string tag, input int ch, input int exp_ticks,
                            input int exp_tp, input int exp_done);
        logic [TW-1:0] t;
        t = ticks[ch*TW +: TW];
        check_eq({tag, " ticks"}, int'(t), exp_ticks);
        check_eq({tag, " pulse"}, int'(tick_pulse[ch]), exp_tp);
        check_eq({tag, " done"}, int'(done[ch]), exp_done);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 2'b00;
        pause     = 2'b00;
        wrap_mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_ch("reset ch0", 0, 0, 0, 0);
        check_ch("reset ch1", 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: saturate; the mid-run wrap_mode change must be ignored
        start = 2'b01;
        step();
        check_ch("sat e0", 0, 0, 0, 0);
        for (int e = 1; e <= 60; e++) begin
            if (e == 5) wrap_mode[0] = 1'b1;
            step();
            check_ch($sformatf("sat e%0d", e), 0, (e >= 50) ? 5 : e / 10,
                     int'(e % 10 == 0 && e <= 50), int'(e >= 50));
        end
        start = 2'b00;
        wrap_mode = 2'b00;
        step();
        check_ch("sat stop", 0, 0, 0, 0);

        // 2: wrap
        wrap_mode = 2'b01;
        start = 2'b01;
        step();
        wrap_mode = 2'b00;
        for (int e = 1; e <= 60; e++) begin
            step();
            check_ch($sformatf("wrap e%0d", e), 0, (e / 10) % 5,
                     int'(e % 10 == 0), int'(e == 50));
        end
        start = 2'b00;
        step();
        check_ch("wrap stop", 0, 0, 0, 0);

        // 3: pause across edges 25..31
        start = 2'b01;
        step();
        for (int e = 1; e <= 50; e++) begin
            pause[0] = (e >= 25 && e <= 31);
            step();
            check_ch($sformatf("pause e%0d", e), 0,
                     int'(e >= 10) + int'(e >= 20) + int'(e >= 37) + int'(e >= 47),
                     int'(e == 10 || e == 20 || e == 37 || e == 47), 0);
        end
        pause = 2'b00;
        start = 2'b00;
        step();

        // 4: independence; ch1 enters RUN at edge 3, ch0 drops at edge 35
        start = 2'b01;
        step();
        for (int e = 1; e <= 45; e++) begin
            start[1] = (e >= 3);
            start[0] = (e < 35);
            step();
            check_ch($sformatf("ind ch0 e%0d", e), 0,
                     (e < 35) ? int'(e >= 10) + int'(e >= 20) + int'(e >= 30) : 0,
                     int'(e == 10 || e == 20 || e == 30), 0);
            check_ch($sformatf("ind ch1 e%0d", e), 1,
                     int'(e >= 13) + int'(e >= 23) + int'(e >= 33) + int'(e >= 43),
                     int'(e == 13 || e == 23 || e == 33 || e == 43), 0);
        end
        start = 2'b00;
        step();
        check_ch("ind stop ch1", 1, 0, 0, 0);

        // 5a: start=0 with pause=1
        start = 2'b01;
        step();
        repeat (14) step();
        check_ch("prio pre e14", 0, 1, 0, 0);
        start = 2'b00;
        pause = 2'b01;
        step();
        check_ch("prio stop+pause", 0, 0, 0, 0);
        step();
        check_ch("prio idle", 0, 0, 0, 0);
        pause = 2'b00;

        // 5b: start=0 on the tick edge drops the tick
        start = 2'b01;
        step();
        repeat (9) step();
        check_ch("prio pre e9", 0, 0, 0, 0);
        start = 2'b00;
        step();
        check_ch("prio stop on tick", 0, 0, 0, 0);
        step();
        check_ch("prio stop after", 0, 0, 0, 0);

        // 6: async reset mid-count
        start = 2'b01;
        step();
        repeat (25) step();
        check_ch("arst pre", 0, 2, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_ch("arst immediate", 0, 0, 0, 0);
        check_eq("arst all ticks", int'(ticks), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_ch("arst e0", 0, 0, 0, 0);
        for (int e = 1; e <= 11; e++) begin
            step();
            check_ch($sformatf("arst e%0d", e), 0, int'(e >= 10), int'(e == 10), 0);
        end
        start = 2'b00;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
